regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Schedules the single write port of the operand-prep register file between two writeback requesters: ALU results and memory loads. Arbitrates with memory priority plus an anti-starvation override for the ALU, and registers the winning write onto `regWrite`/`writeRegister`/`writeData`. Drives a decode stall whenever a source register read would race an unfinished write. It sits between the writeback stage and the operand-prep stage.

## Interface
- `STARVE_LIMIT`, 3: consecutive cycles the ALU may be refused before it is forced to win (1..15).
- `ZERO_REG`, 31: register address treated as XZR; writes are discarded, never a hazard.
- `clock` in 1: main clock, rising edge.
- `nReset` in 1: reset, asynchronous, active-low.
- `aluWbValid` in 1: ALU write request.
- `aluWbReg` in 5: ALU destination register.
- `aluWbData` in 32: ALU result.
- `aluWbReady` out 1: ALU request accepted this cycle.
- `memWbValid` in 1: memory load write request.
- `memWbReg` in 5: load destination register.
- `memWbData` in 32: load data.
- `memWbReady` out 1: memory request accepted this cycle.
- `decValid` in 1: decode presents a read of `decReg1`/`decReg2`.
- `decReg1` in 5: first source register.
- `decReg2` in 5: second source register.
- `decStall` out 1: hold decode; operands not yet safe to read.
- `regWrite` out 1: register file write enable.
- `writeRegister` out 5: register file write address.
- `writeData` out 32: register file write data.

## Operation
- Transfer on a port occurs when valid and ready are both high at a rising edge. The requester holds valid, reg, and data stable until the transfer.
- `forceAlu` = (`starveCnt` >= `STARVE_LIMIT`).
- `memWbReady` = `nReset` & ~`forceAlu`.
- `aluWbReady` = `nReset` & (~`memWbValid` | `forceAlu`).
- At most one transfer per cycle. Ready may be high with valid low; this is not a transfer.
- `starveCnt`, width ceil(log2(`STARVE_LIMIT`+1)):
  - Increments, saturating, when `aluWbValid` & ~`aluWbReady`.
  - Clears on an ALU transfer or when `aluWbValid` is low.
  - Otherwise holds.
- On a transfer, the output register loads the winner's reg/data next edge:
  - `regWrite` = 1 unless reg == `ZERO_REG`.
  - For reg == `ZERO_REG`, the transfer completes but `regWrite` = 0, and `writeRegister`/`writeData` still update.
- No transfer: `regWrite` = 0 next cycle; `writeRegister`/`writeData` hold.
- Hazard set:
  - `aluWbReg` if `aluWbValid`.
  - `memWbReg` if `memWbValid`.
  - `writeRegister` if `regWrite`.
  - `ZERO_REG` is excluded from every entry.
- `decStall` = `decValid` & `nReset` & (`decReg1` or `decReg2` is in the hazard set). Combinational.

## Timing
- Reset values: `regWrite` 0, `writeRegister` 0, `writeData` 0, `starveCnt` 0. All readies and `decStall` are 0 while `nReset` is low.
- Latency: a transfer at edge N gives `regWrite` high during cycle N..N+1. The register file commits at edge N+1.
- Back-to-back transfers are allowed every cycle: full throughput of one write per cycle.
- Simultaneous valid, `starveCnt` < `STARVE_LIMIT`: memory wins. At the limit: ALU wins, and memory waits one cycle.
- Both requesters targeting the same register in consecutive cycles: writes apply in grant order; the later grant's data persists.
- Reset mid-operation: in-flight write is dropped (`regWrite` forced 0 asynchronously) and the counter clears. Unaccepted requests must be re-presented after reset.

## Test plan
- **Reset:** assert `nReset`=0 mid-write with `regWrite`=1 -> `regWrite` drops to 0 immediately; readies=0; after release, first `memWbValid` with reg 5, data 0xDEADBEEF -> `regWrite`=1, `writeRegister`=5, `writeData`=0xDEADBEEF one cycle later.
- **Contention:** hold `aluWbValid` (reg 3) and `memWbValid` (reg 4, new data each cycle) high continuously -> memory wins 3 cycles, ALU wins cycle 4, `starveCnt` returns to 0; repeat pattern M,M,M,A.
- **XZR:** ALU write to reg 31, data 0x12345678 -> `aluWbReady`=1, next cycle `regWrite`=0; `decReg1`=31 with that request pending -> `decStall`=0.
- **Hazard:** `memWbValid` pending reg 7 (ALU forced) while `decValid`, `decReg2`=7 -> `decStall`=1 until the cycle after `regWrite`=1 with `writeRegister`=7; it drops to 0 the following cycle.
- **Throughput:** ALU alone, 8 consecutive requests regs 1..8 -> 8 consecutive cycles `regWrite`=1, addresses 1..8 in order, `aluWbReady` never low.
- **Idle readiness:** `memWbValid`=0 and `aluWbValid`=0 -> `aluWbReady`=1 and `memWbReady`=1; `regWrite` stays 0; `starveCnt` stays 0.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Shares the single register-file write port between ALU writeback and
// memory-load writeback. Memory normally wins; an ALU requester that has been
// refused STARVE_LIMIT consecutive cycles is forced through. The winning write
// is registered onto regWrite/writeRegister/writeData, and decode is stalled
// while any source register still has a write in flight.
module regfile_write_scheduler #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned ZERO_REG     = 31
) (
  input  logic        clock,
  input  logic        nReset,

  input  logic        aluWbValid,
  input  logic [4:0]  aluWbReg,
  input  logic [31:0] aluWbData,
  output logic        aluWbReady,

  input  logic        memWbValid,
  input  logic [4:0]  memWbReg,
  input  logic [31:0] memWbData,
  output logic        memWbReady,

  input  logic        decValid,
  input  logic [4:0]  decReg1,
  input  logic [4:0]  decReg2,
  output logic        decStall,

  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData
);

  localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [4:0]       ZR    = 5'(ZERO_REG);

  // Starvation counter and registered write port
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;

  // Arbitration terms
  logic force_alu;
  logic alu_ready;
  logic mem_ready;
  logic alu_xfer;
  logic mem_xfer;

  // Hazard terms
  logic alu_hit;
  logic mem_hit;
  logic out_hit;

  // Grant: memory by default, ALU when memory is idle or the ALU is starving
  always_comb begin
    force_alu = (starve_cnt_q >= LIMIT);
    mem_ready = nReset & ~force_alu;
    alu_ready = nReset & (~memWbValid | force_alu);
    alu_xfer  = aluWbValid & alu_ready;
    mem_xfer  = memWbValid & mem_ready;
  end

  assign aluWbReady = alu_ready;
  assign memWbReady = mem_ready;

  // Starvation counter: counts refused ALU cycles, clears on grant or idle
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!aluWbValid || alu_xfer) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Write-port next state: load the winner, XZR writes update address/data only
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (mem_xfer) begin
      reg_write_d  = (memWbReg != ZR);
      write_reg_d  = memWbReg;
      write_data_d = memWbData;
    end else if (alu_xfer) begin
      reg_write_d  = (aluWbReg != ZR);
      write_reg_d  = aluWbReg;
      write_data_d = aluWbData;
    end
  end

  // State registers; reset drops any in-flight write immediately
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      starve_cnt_q <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign regWrite      = reg_write_q;
  assign writeRegister = write_reg_q;
  assign writeData     = write_data_q;

  // Hazard detection: either source matching a pending or committing write
  always_comb begin
    alu_hit  = aluWbValid && (aluWbReg != ZR) &&
               ((decReg1 == aluWbReg) || (decReg2 == aluWbReg));
    mem_hit  = memWbValid && (memWbReg != ZR) &&
               ((decReg1 == memWbReg) || (decReg2 == memWbReg));
    out_hit  = reg_write_q && (write_reg_q != ZR) &&
               ((decReg1 == write_reg_q) || (decReg2 == write_reg_q));
    decStall = decValid & nReset & (alu_hit | mem_hit | out_hit);
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: stimulus pushes expected writes
// into a queue; a negedge monitor pops and checks them against the write port.
module tb_regfile_write_scheduler;

  logic        clock = 1'b0;
  logic        nReset;
  logic        aluWbValid;
  logic [4:0]  aluWbReg;
  logic [31:0] aluWbData;
  logic        aluWbReady;
  logic        memWbValid;
  logic [4:0]  memWbReg;
  logic [31:0] memWbData;
  logic        memWbReady;
  logic        decValid;
  logic [4:0]  decReg1;
  logic [4:0]  decReg2;
  logic        decStall;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  always #5 clock = ~clock;

  regfile_write_scheduler #(
    .STARVE_LIMIT(3),
    .ZERO_REG(31)
  ) dut (
    .clock(clock),
    .nReset(nReset),
    .aluWbValid(aluWbValid),
    .aluWbReg(aluWbReg),
    .aluWbData(aluWbData),
    .aluWbReady(aluWbReady),
    .memWbValid(memWbValid),
    .memWbReg(memWbReg),
    .memWbData(memWbData),
    .memWbReady(memWbReady),
    .decValid(decValid),
    .decReg1(decReg1),
    .decReg2(decReg2),
    .decStall(decStall),
    .regWrite(regWrite),
    .writeRegister(writeRegister),
    .writeData(writeData)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected write lands on the port in the cycle after the transfer edge
  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r   = r;
    e.d   = d;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Check combinational outputs mid-cycle, then advance one clock
  task automatic step(input logic ea, input logic em, input logic es, input string nm);
    @(negedge clock);
    chk({nm, "_aluRdy"}, 32'(aluWbReady), 32'(ea));
    chk({nm, "_memRdy"}, 32'(memWbReady), 32'(em));
    chk({nm, "_stall"},  32'(decStall),   32'(es));
    @(posedge clock);
    #1;
  endtask

  // Monitor: every write-port cycle must match the head of the queue
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (nReset === 1'b1) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk("wr_en",   32'(regWrite),      32'd1);
          chk("wr_reg",  32'(writeRegister), 32'(e.r));
          chk("wr_data", writeData,          e.d);
        end else if (regWrite !== 1'b0) begin
          chk("unexpected_wr", 32'(regWrite), 32'd0);
        end
      end
    end
  end

  logic [31:0] mseq;
  logic [31:0] adata;

  initial begin
    nReset     = 1'b0;
    aluWbValid = 1'b0; aluWbReg = '0; aluWbData = '0;
    memWbValid = 1'b1; memWbReg = 5'd5; memWbData = 32'h1;
    decValid   = 1'b1; decReg1 = 5'd5; decReg2 = 5'd0;
    #1;
    chk("rst_regWrite", 32'(regWrite),      32'd0);
    chk("rst_wreg",     32'(writeRegister), 32'd0);
    chk("rst_wdata",    writeData,          32'd0);
    chk("rst_aluRdy",   32'(aluWbReady),    32'd0);
    chk("rst_memRdy",   32'(memWbReady),    32'd0);
    chk("rst_stall",    32'(decStall),      32'd0);
    memWbValid = 1'b0; decValid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;

    // Idle: both ready, no writes
    repeat (3) step(1'b1, 1'b1, 1'b0, "idle");

    // Throughput: ALU alone, regs 1..8 back to back
    for (int i = 1; i <= 8; i++) begin
      aluWbValid = 1'b1; aluWbReg = 5'(i); aluWbData = 32'hA000_0000 + 32'(i);
      expect_wr(5'(i), 32'hA000_0000 + 32'(i));
      step(1'b1, 1'b1, 1'b0, "thru");
    end
    aluWbValid = 1'b0;

    // Contention: M,M,M,A twice, memory holding data until accepted
    mseq = 32'hB000_0000;
    for (int rnd = 0; rnd < 2; rnd++) begin
      aluWbValid = 1'b1; aluWbReg = 5'd3; aluWbData = 32'hA1A1_0000 + 32'(rnd);
      memWbValid = 1'b1; memWbReg = 5'd4;
      for (int k = 0; k < 3; k++) begin
        memWbData = mseq;
        expect_wr(5'd4, mseq);
        step(1'b0, 1'b1, 1'b0, "cont_mem");
        mseq = mseq + 32'd1;
      end
      memWbData = mseq;
      expect_wr(5'd3, 32'hA1A1_0000 + 32'(rnd));
      step(1'b1, 1'b0, 1'b0, "cont_alu");
    end
    aluWbValid = 1'b0;
    expect_wr(5'd4, mseq);
    step(1'b0, 1'b1, 1'b0, "cont_drain");
    memWbValid = 1'b0;

    // XZR: transfer accepted, no write enable, never a hazard
    aluWbValid = 1'b1; aluWbReg = 5'd31; aluWbData = 32'h1234_5678;
    decValid = 1'b1; decReg1 = 5'd31; decReg2 = 5'd6;
    step(1'b1, 1'b1, 1'b0, "xzr");
    aluWbValid = 1'b0;
    @(negedge clock);
    chk("xzr_wreg",  32'(writeRegister), 32'd31);
    chk("xzr_wdata", writeData,          32'h1234_5678);
    chk("xzr_stall", 32'(decStall),      32'd0);
    @(posedge clock);
    #1;

    // Hazard: build starvation, then memory reg 7 waits behind forced ALU
    decValid = 1'b1; decReg1 = 5'd20; decReg2 = 5'd7;
    aluWbValid = 1'b1; aluWbReg = 5'd10; aluWbData = 32'hC0DE_000A;
    memWbValid = 1'b1; memWbReg = 5'd11;
    for (int k = 0; k < 3; k++) begin
      memWbData = 32'hD000_0000 + 32'(k);
      expect_wr(5'd11, 32'hD000_0000 + 32'(k));
      step(1'b0, 1'b1, 1'b0, "haz_pre");
    end
    memWbReg = 5'd7; memWbData = 32'h7777_0007;
    expect_wr(5'd10, 32'hC0DE_000A);
    step(1'b1, 1'b0, 1'b1, "haz_forced");
    aluWbValid = 1'b0;
    expect_wr(5'd7, 32'h7777_0007);
    step(1'b0, 1'b1, 1'b1, "haz_memwin");
    memWbValid = 1'b0;
    step(1'b1, 1'b1, 1'b1, "haz_wb");
    step(1'b1, 1'b1, 1'b0, "haz_clear");
    decValid = 1'b0;

    // Reset mid-write: regWrite drops at once, queued write is discarded
    memWbValid = 1'b1; memWbReg = 5'd9; memWbData = 32'h0000_0099;
    expect_wr(5'd9, 32'h0000_0099);
    step(1'b0, 1'b1, 1'b0, "rst_pre");
    memWbValid = 1'b0;
    chk("rst_pre_wen", 32'(regWrite), 32'd1);
    nReset = 1'b0;
    decValid = 1'b1; decReg1 = 5'd9;
    #1;
    exp_q.delete();
    chk("rst_mid_regWrite", 32'(regWrite),      32'd0);
    chk("rst_mid_wreg",     32'(writeRegister), 32'd0);
    chk("rst_mid_wdata",    writeData,          32'd0);
    chk("rst_mid_aluRdy",   32'(aluWbReady),    32'd0);
    chk("rst_mid_memRdy",   32'(memWbReady),    32'd0);
    chk("rst_mid_stall",    32'(decStall),      32'd0);
    @(posedge clock);
    #1;
    nReset = 1'b1;
    decValid = 1'b0;
    memWbValid = 1'b1; memWbReg = 5'd5; memWbData = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, "rst_first");
    memWbValid = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b0, "tail");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
